eu_sequencer: RTL and testbench

Multi-cycle controller that sequences the execution unit's arithmetic datapath (eu_arithmetic) for one instruction at a time. It accepts a decoded arithmetic instruction over a valid/ready handshake and reads both source operands from the register file. It then drives the arithmetic unit's A/B/op_select, captures data_out and zero, writes the result back and updates a sticky zero status flag. It sits between the instruction decoder and the register file / arithmetic unit.

---
 rtl/eu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_eu_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_sequencer.sv
// eu_sequencer: runs one arithmetic instruction at a time through a fixed
// IDLE -> READ -> EXEC -> WB sequence. It reads both source registers, drives
// eu_arithmetic, writes the result back and keeps a sticky zero status flag.
module eu_sequencer #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            instr_op,
    input  logic [ADDR_WIDTH-1:0] instr_rd,
    input  logic [ADDR_WIDTH-1:0] instr_ra,
    input  logic [ADDR_WIDTH-1:0] instr_rb,
    output logic [ADDR_WIDTH-1:0] rf_ra_addr,
    output logic [ADDR_WIDTH-1:0] rf_rb_addr,
    input  logic [BUS_WIDTH-1:0]  rf_ra_data,
    input  logic [BUS_WIDTH-1:0]  rf_rb_data,
    output logic [BUS_WIDTH-1:0]  alu_a,
    output logic [BUS_WIDTH-1:0]  alu_b,
    output logic [3:0]            alu_op_select,
    input  logic [BUS_WIDTH-1:0]  alu_data_out,
    input  logic                  alu_zero,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wa,
    output logic [BUS_WIDTH-1:0]  rf_wd,
    output logic                  done,
    output logic                  illegal,
    output logic                  zero_flag
);

    localparam int unsigned OP_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  ready_next;
    logic                  we_next;
    logic                  done_next;
    logic                  illegal_next;
    logic [OP_WIDTH-1:0]   ir_op;
    logic [ADDR_WIDTH-1:0] ir_rd;
    logic                  ir_illegal;
    logic                  res_zero;

    // Supported micro-ops: MOVA, INC, ADD, SUB, DEC.
    function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of the registered handshake/pulse outputs.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        ready_next   = 1'b0;
        we_next      = 1'b0;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept     = 1'b1;
                    state_next = READ;
                end else begin
                    ready_next = 1'b1;
                end
            end
            READ: begin
                state_next = EXEC;
            end
            EXEC: begin
                state_next   = WB;
                we_next      = ~ir_illegal;
                done_next    = 1'b1;
                illegal_next = ir_illegal;
            end
            WB: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // Handshake and retire pulses, registered so each is one clean cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b1;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            instr_ready <= ready_next;
            rf_we       <= we_next;
            done        <= done_next;
            illegal     <= illegal_next;
        end
    end

    // Instruction register; read addresses come straight from the latched ra/rb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_op      <= '0;
            ir_rd      <= '0;
            ir_illegal <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
        end else if (accept) begin
            ir_op      <= instr_op;
            ir_rd      <= instr_rd;
            ir_illegal <= ~op_legal(instr_op);
            rf_ra_addr <= instr_ra;
            rf_rb_addr <= instr_rb;
        end
    end

    // Operand capture at the end of READ; these registers drive the ALU in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op_select <= '0;
        end else if (state == READ) begin
            alu_a         <= rf_ra_data;
            alu_b         <= rf_rb_data;
            alu_op_select <= ir_op;
        end
    end

    // Result capture at the end of EXEC; presented to the register file in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wa    <= '0;
            rf_wd    <= '0;
            res_zero <= 1'b0;
        end else if (state == EXEC) begin
            rf_wa    <= ir_rd;
            rf_wd    <= alu_data_out;
            res_zero <= alu_zero;
        end
    end

    // Sticky zero status, updated only when a legal instruction retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
        end else if (state == WB && !ir_illegal) begin
            zero_flag <= res_zero;
        end
    end

endmodule

// File: tb/tb_eu_sequencer.sv
// Testbench for eu_sequencer: register file and arithmetic unit models around
// the DUT, a hand-written vector table, back-to-back and reset sequences, and
// randomized instructions checked against an instruction-level model.
module tb_eu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_ra;
    logic [2:0]  instr_rb;
    logic [2:0]  rf_ra_addr;
    logic [2:0]  rf_rb_addr;
    logic [15:0] rf_ra_data;
    logic [15:0] rf_rb_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op_select;
    logic [15:0] alu_data_out;
    logic        alu_zero;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        done;
    logic        illegal;
    logic        zero_flag;

    int n_vec = 0;
    int n_err = 0;

    eu_sequencer #(.BUS_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_ra     (instr_ra),
        .instr_rb     (instr_rb),
        .rf_ra_addr   (rf_ra_addr),
        .rf_rb_addr   (rf_rb_addr),
        .rf_ra_data   (rf_ra_data),
        .rf_rb_data   (rf_rb_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op_select(alu_op_select),
        .alu_data_out (alu_data_out),
        .alu_zero     (alu_zero),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .done         (done),
        .illegal      (illegal),
        .zero_flag    (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: combinational read, write on rising edge.
    logic [15:0] rf [8];
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];
    always @(posedge clk) begin
        if (pre_en) rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_wa] <= rf_wd;
    end

    // Arithmetic unit environment; unsupported codes give a XOR so zero may be set.
    always_comb begin
        case (alu_op_select)
            4'b0000: alu_data_out = alu_a;
            4'b0001: alu_data_out = alu_a + 16'd1;
            4'b0010: alu_data_out = alu_a + alu_b;
            4'b0101: alu_data_out = alu_a - alu_b;
            4'b0110: alu_data_out = alu_a - 16'd1;
            default: alu_data_out = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_data_out == 16'd0);
    end

    // Instruction-level model state.
    logic [15:0] m_rf [8];
    logic        m_zero;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] wd;
        logic        ill;
        logic        zf;
    } vec_t;

    vec_t        tbl [9];
    logic [3:0]  legal_ops [5];
    logic [18:0] exp_q [$];

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
        end
    endtask

    // Result of one instruction from its arithmetic meaning: {legal, value}.
    function automatic logic [16:0] ref_op(input logic [3:0] op,
                                           input logic [15:0] a, input logic [15:0] b);
        int unsigned s;
        logic        legal;
        legal = 1'b1;
        case (op)
            4'd0:    s = 32'(a);
            4'd1:    s = 32'(a) + 32'd1;
            4'd2:    s = 32'(a) + 32'(b);
            4'd5:    s = 32'(a) + 32'd65536 - 32'(b);
            4'd6:    s = 32'(a) + 32'd65535;
            default: begin s = 32'd0; legal = 1'b0; end
        endcase
        return {legal, 16'(s % 32'd65536)};
    endfunction

    task automatic commit(input logic [2:0] rd, input logic [16:0] r, input logic zf);
        if (r[16]) m_rf[rd] = r[15:0];
        m_zero = zf;
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_en   = 1'b0;
        m_rf[addr] = data;
    endtask

    // Issue one instruction and check every phase of its execution.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] exp_wd, input logic exp_ill,
                         input logic exp_zf, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(tag, "ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        @(negedge clk);
        instr_valid = 1'b0;
        check(tag, "read_ready", 32'(instr_ready), 32'd0);
        check(tag, "read_done", 32'(done), 32'd0);
        check(tag, "read_ra_addr", 32'(rf_ra_addr), 32'(ra));
        check(tag, "read_rb_addr", 32'(rf_rb_addr), 32'(rb));
        @(negedge clk);
        check(tag, "exec_alu_a", 32'(alu_a), 32'(m_rf[ra]));
        check(tag, "exec_alu_b", 32'(alu_b), 32'(m_rf[rb]));
        check(tag, "exec_op", 32'(alu_op_select), 32'(op));
        check(tag, "exec_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        check(tag, "wb_done", 32'(done), 32'd1);
        check(tag, "wb_illegal", 32'(illegal), 32'(exp_ill));
        check(tag, "wb_we", 32'(rf_we), 32'(!exp_ill));
        if (!exp_ill) begin
            check(tag, "wb_wa", 32'(rf_wa), 32'(rd));
            check(tag, "wb_wd", 32'(rf_wd), 32'(exp_wd));
        end
        @(negedge clk);
        check(tag, "idle_zero_flag", 32'(zero_flag), 32'(exp_zf));
        check(tag, "idle_ready", 32'(instr_ready), 32'd1);
        check(tag, "idle_done", 32'(done), 32'd0);
    endtask

    // Issue with expectations taken from the model.
    task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input string tag);
        logic [16:0] r;
        logic        zf;
        r  = ref_op(op, m_rf[ra], m_rf[rb]);
        zf = r[16] ? (r[15:0] == 16'd0) : m_zero;
        issue(op, rd, ra, rb, r[15:0], ~r[16], zf, tag);
        commit(rd, r, zf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] r;
        logic        zf;
        int          idx;
        int          n_done;
        int          n;
        logic [3:0]  bop [3];
        logic [2:0]  brd [3];
        logic [2:0]  bra [3];
        logic [2:0]  brb [3];

        tbl[0] = '{4'h5, 3'd3, 3'd1, 3'd2, 16'h00F0, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 3'd6, 3'd1, 3'd1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{4'h1, 3'd4, 3'd4, 3'd0, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{4'h3, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{4'h2, 3'd5, 3'd1, 3'd2, 16'h010E, 1'b0, 1'b0};
        tbl[5] = '{4'h6, 3'd6, 3'd0, 3'd1, 16'hFFFF, 1'b0, 1'b0};
        tbl[6] = '{4'h0, 3'd7, 3'd0, 3'd2, 16'h0000, 1'b0, 1'b1};
        tbl[7] = '{4'h2, 3'd1, 3'd1, 3'd1, 16'h01FE, 1'b0, 1'b0};
        tbl[8] = '{4'h5, 3'd2, 3'd2, 3'd2, 16'h0000, 1'b0, 1'b1};
        legal_ops[0] = 4'h0; legal_ops[1] = 4'h1; legal_ops[2] = 4'h2;
        legal_ops[3] = 4'h5; legal_ops[4] = 4'h6;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_ra = '0; instr_rb = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        m_zero = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset", "instr_ready", 32'(instr_ready), 32'd1);
        check("reset", "rf_we", 32'(rf_we), 32'd0);
        check("reset", "done", 32'(done), 32'd0);
        check("reset", "illegal", 32'(illegal), 32'd0);
        check("reset", "zero_flag", 32'(zero_flag), 32'd0);
        check("reset", "alu_a", 32'(alu_a), 32'd0);
        check("reset", "rf_wd", 32'(rf_wd), 32'd0);
        rst_n = 1'b1;

        // Directed table.
        preload(3'd0, 16'h0000); preload(3'd1, 16'h00FF); preload(3'd2, 16'h000F);
        preload(3'd3, 16'h1234); preload(3'd4, 16'hFFFF); preload(3'd5, 16'h0000);
        preload(3'd6, 16'h0000); preload(3'd7, 16'h0000);
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].wd, tbl[i].ill,
                  tbl[i].zf, $sformatf("tbl%0d", i));
            commit(tbl[i].rd, ref_op(tbl[i].op, m_rf[tbl[i].ra], m_rf[tbl[i].rb]), tbl[i].zf);
        end

        // Back-to-back: valid held high across three dependent instructions.
        preload(3'd1, 16'h0100); preload(3'd2, 16'h0023);
        bop = '{4'h2, 4'h5, 4'h1};
        brd = '{3'd3, 3'd4, 3'd3};
        bra = '{3'd1, 3'd3, 3'd3};
        brb = '{3'd2, 3'd1, 3'd0};
        idx = 0; n_done = 0; n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc < 12) begin
                check("b2b", $sformatf("ready_c%0d", cyc), 32'(instr_ready), 32'(cyc % 4 == 0));
                check("b2b", $sformatf("done_c%0d", cyc), 32'(done), 32'(cyc % 4 == 3));
            end
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("b2b", "unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("b2b", "wa", 32'(rf_wa), 32'(exp_q[0][18:16]));
                    check("b2b", "wd", 32'(rf_wd), 32'(exp_q[0][15:0]));
                    void'(exp_q.pop_front());
                end
            end
            if (instr_ready) begin
                if (idx < 3) begin
                    instr_valid = 1'b1;
                    instr_op = bop[idx]; instr_rd = brd[idx];
                    instr_ra = bra[idx]; instr_rb = brb[idx];
                    r  = ref_op(bop[idx], m_rf[bra[idx]], m_rf[brb[idx]]);
                    zf = r[16] ? (r[15:0] == 16'd0) : m_zero;
                    exp_q.push_back({brd[idx], r[15:0]});
                    commit(brd[idx], r, zf);
                    idx++;
                end else begin
                    instr_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b", "done_count", 32'(n_done), 32'd3);

        // Reset during EXEC of an ADD: zero_flag set first so the clear is visible.
        preload(3'd0, 16'h0000);
        run(4'h0, 3'd7, 3'd0, 3'd0, "pre_rst_mova");
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        instr_valid = 1'b1; instr_op = 4'h2; instr_rd = 3'd5; instr_ra = 3'd1; instr_rb = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec", "instr_ready", 32'(instr_ready), 32'd1);
        check("rst_exec", "zero_flag", 32'(zero_flag), 32'd0);
        check("rst_exec", "alu_a", 32'(alu_a), 32'd0);
        check("rst_exec", "alu_op", 32'(alu_op_select), 32'd0);
        check("rst_exec", "rf_ra_addr", 32'(rf_ra_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", "rf_we", 32'(rf_we), 32'd0);
            check("rst_hold", "done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        m_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_after", "rf_we", 32'(rf_we), 32'd0);
            check("rst_after", "done", 32'(done), 32'd0);
            check("rst_after", "instr_ready", 32'(instr_ready), 32'd1);
        end
        check("rst_after", "r5_unwritten", 32'(rf[5]), 32'(m_rf[5]));
        run(4'h2, 3'd5, 3'd1, 3'd2, "post_rst_add");

        // Randomized instructions against the model.
        for (int i = 0; i < 8; i++) preload(3'(i), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 4)];
            else op = 4'($urandom_range(0, 15));
            run(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
